// File: rtl/rename_free_list.sv
// Circular free list of physical-register tags for the rename stage.
// Hands out up to ALLOC_WIDTH tags per cycle, takes back RELEASE_WIDTH, and checkpoints the head.
module rename_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int ALLOC_WIDTH   = 2,
  parameter int RELEASE_WIDTH = 2,
  parameter int NUM_CKPT      = 4,
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int PW    = $clog2(NUM_PHYS_REGS),
  localparam int CW    = $clog2(NUM_CKPT),
  localparam int AW    = $clog2(ALLOC_WIDTH + 1),
  localparam int FCW   = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AW-1:0]               alloc_cnt,
  output logic                        alloc_ready,
  output logic [ALLOC_WIDTH*PW-1:0]   alloc_preg,
  input  logic [RELEASE_WIDTH-1:0]    rel_valid,
  input  logic [RELEASE_WIDTH*PW-1:0] rel_preg,
  input  logic                        ckpt_save,
  input  logic [CW-1:0]               ckpt_save_id,
  input  logic                        restore_valid,
  input  logic [CW-1:0]               restore_id,
  output logic [FCW-1:0]              free_count,
  output logic                        overflow_err
);

  localparam int IW   = $clog2(DEPTH);
  localparam int PTRW = IW + 1;

  logic [PW-1:0]            fifo_q [DEPTH];
  logic [PTRW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [PTRW-1:0]          ckpt_q [NUM_CKPT];
  logic [NUM_CKPT-1:0]      ckpt_vld_q;
  logic                     overflow_q;

  logic [RELEASE_WIDTH-1:0] rel_eff;
  logic [IW-1:0]            rel_off [RELEASE_WIDTH];
  logic [IW-1:0]            wr_idx  [RELEASE_WIDTH];
  logic [PTRW-1:0]          rel_cnt, free_cur, free_after;
  logic                     alloc_fire, rel_drop, dup_found;

  assign free_cur     = tail_q - head_q;
  assign alloc_ready  = free_cur >= PTRW'(ALLOC_WIDTH);
  assign free_count   = FCW'(free_cur);
  assign overflow_err = overflow_q;

  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_lane
      assign alloc_preg[gi*PW +: PW] = fifo_q[head_q[IW-1:0] + IW'(gi)];
    end
    // Tag 0 is the hard-wired zero register and must never re-enter the list.
    for (gi = 0; gi < RELEASE_WIDTH; gi++) begin : g_rel_lane
      assign rel_eff[gi] = rel_valid[gi] && (rel_preg[gi*PW +: PW] != '0);
      assign wr_idx[gi]  = tail_q[IW-1:0] + rel_off[gi];
    end
  endgenerate

  // Compact valid release lanes onto consecutive tail slots.
  always_comb begin
    rel_cnt = '0;
    for (int r = 0; r < RELEASE_WIDTH; r++) begin
      rel_off[r] = rel_cnt[IW-1:0];
      rel_cnt    = rel_cnt + PTRW'(rel_eff[r]);
    end
  end

  always_comb begin
    alloc_fire = (alloc_cnt != '0) && alloc_ready && !restore_valid;
    head_d     = head_q;
    if (restore_valid)   head_d = ckpt_q[restore_id];
    else if (alloc_fire) head_d = head_q + PTRW'(alloc_cnt);
    free_after = tail_q - head_d;
    rel_drop   = ({1'b0, free_after} + {1'b0, rel_cnt}) > (PTRW+1)'(DEPTH);
    tail_d     = rel_drop ? tail_q : tail_q + rel_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= PTRW'(DEPTH);
      overflow_q <= 1'b0;
      ckpt_vld_q <= '0;
      for (int c = 0; c < NUM_CKPT; c++) ckpt_q[c] <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= PW'(NUM_ARCH_REGS + i);
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_q | rel_drop;
      if (ckpt_save && !restore_valid) begin
        ckpt_q[ckpt_save_id]     <= head_d;
        ckpt_vld_q[ckpt_save_id] <= 1'b1;
      end
      if (!rel_drop) begin
        for (int r = 0; r < RELEASE_WIDTH; r++)
          if (rel_eff[r]) fifo_q[wr_idx[r]] <= rel_preg[r*PW +: PW];
      end
    end
  end

  // Pairwise scan of the live window; only feeds the integrity check below.
  always_comb begin
    dup_found = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < i; j++)
        if (PTRW'(i) < free_cur &&
            fifo_q[head_q[IW-1:0] + IW'(i)] == fifo_q[head_q[IW-1:0] + IW'(j)])
          dup_found = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (alloc_cnt <= AW'(ALLOC_WIDTH)) else $error("alloc_cnt above ALLOC_WIDTH");
      assert (!restore_valid || ckpt_vld_q[restore_id]) else $error("restore of unsaved checkpoint");
      assert (!dup_found) else $error("duplicate tag in free list");
    end
  end

endmodule

// File: tb/tb_rename_free_list.sv
// Directed bench for rename_free_list: drain, release, overflow, checkpoints, wrap and reset.
// Each task drives a scenario and compares DUT outputs against hand-derived values.
module tb_rename_free_list;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alloc_cnt;
  logic        alloc_ready;
  logic [11:0] alloc_preg;
  logic [1:0]  rel_valid;
  logic [11:0] rel_preg;
  logic        ckpt_save;
  logic [1:0]  ckpt_save_id;
  logic        restore_valid;
  logic [1:0]  restore_id;
  logic [5:0]  free_count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  rename_free_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_cnt(alloc_cnt), .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
    .rel_valid(rel_valid), .rel_preg(rel_preg),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .restore_valid(restore_valid), .restore_id(restore_id),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_cnt = 2'd0; rel_valid = 2'b00; rel_preg = '0;
    ckpt_save = 1'b0; ckpt_save_id = 2'd0; restore_valid = 1'b0; restore_id = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    $display("reset: free=%0d ready=%0d ovf=%0d preg=(%0d,%0d)",
             free_count, alloc_ready, overflow_err, alloc_preg[5:0], alloc_preg[11:6]);
    n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL reset_free got %0d want 32", free_count); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0d want 1", alloc_ready); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0d want 0", overflow_err); end
    n_cmp++; if (alloc_preg !== {6'd33, 6'd32}) begin n_err++;
      $display("FAIL reset_preg got (%0d,%0d) want (32,33)", alloc_preg[5:0], alloc_preg[11:6]); end
  endtask

  // Assumes reset contents; allocates all 32 tags as 16 pairs.
  task automatic test_alloc_drain();
    for (int k = 0; k < 16; k++) begin
      alloc_cnt = 2'd2;
      n_cmp++; if (alloc_preg !== {6'(33 + 2*k), 6'(32 + 2*k)}) begin n_err++;
        $display("FAIL drain_preg k=%0d got (%0d,%0d) want (%0d,%0d)", k,
                 alloc_preg[5:0], alloc_preg[11:6], 32 + 2*k, 33 + 2*k); end
      step();
      $display("alloc %0d: free=%0d ready=%0d", k, free_count, alloc_ready);
      n_cmp++; if (free_count !== 6'(30 - 2*k)) begin n_err++;
        $display("FAIL drain_free k=%0d got %0d want %0d", k, free_count, 30 - 2*k); end
    end
    alloc_cnt = 2'd0;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL drain_ready got %0d want 0", alloc_ready); end
    alloc_cnt = 2'd2;
    step();
    alloc_cnt = 2'd0;
    $display("stalled alloc: free=%0d", free_count);
    n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL stall_free got %0d want 0", free_count); end
  endtask

  task automatic test_release_from_empty();
    rel_valid = 2'b11; rel_preg = {6'd41, 6'd40};
    step();
    idle_inputs();
    $display("release 40,41: free=%0d ready=%0d", free_count, alloc_ready);
    n_cmp++; if (free_count !== 6'd2) begin n_err++; $display("FAIL relempty_free got %0d want 2", free_count); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL relempty_ready got %0d want 1", alloc_ready); end
    n_cmp++; if (alloc_preg !== {6'd41, 6'd40}) begin n_err++;
      $display("FAIL relempty_preg got (%0d,%0d) want (40,41)", alloc_preg[5:0], alloc_preg[11:6]); end
  endtask

  task automatic test_release_r0();
    rel_valid = 2'b11; rel_preg = {6'd45, 6'd0};
    step();
    idle_inputs();
    $display("release 0,45: free=%0d", free_count);
    n_cmp++; if (free_count !== 6'd3) begin n_err++; $display("FAIL r0_free got %0d want 3", free_count); end
    alloc_cnt = 2'd2;
    step();
    alloc_cnt = 2'd0;
    $display("alloc after r0: free=%0d ready=%0d lane0=%0d", free_count, alloc_ready, alloc_preg[5:0]);
    n_cmp++; if (free_count !== 6'd1) begin n_err++; $display("FAIL r0_alloc_free got %0d want 1", free_count); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL partial_ready got %0d want 0", alloc_ready); end
    n_cmp++; if (alloc_preg[5:0] !== 6'd45) begin n_err++;
      $display("FAIL r0_compact got %0d want 45", alloc_preg[5:0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    rel_valid = 2'b01; rel_preg = {6'd0, 6'd5};
    step();
    idle_inputs();
    $display("overflow release: free=%0d ovf=%0d", free_count, overflow_err);
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set got %0d want 1", overflow_err); end
    n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL ovf_free got %0d want 32", free_count); end
    alloc_cnt = 2'd2;
    step();
    alloc_cnt = 2'd0; rel_valid = 2'b11; rel_preg = {6'd33, 6'd32};
    step();
    idle_inputs();
    $display("traffic after overflow: free=%0d ovf=%0d", free_count, overflow_err);
    n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL ovf_traffic_free got %0d want 32", free_count); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0d want 1", overflow_err); end
    do_reset();
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %0d want 0", overflow_err); end
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    alloc_cnt = 2'd2;
    step();
    ckpt_save = 1'b1; ckpt_save_id = 2'd2;
    step();
    ckpt_save = 1'b0;
    step(); step(); step();
    alloc_cnt = 2'd0;
    $display("after 10 allocs: free=%0d", free_count);
    n_cmp++; if (free_count !== 6'd22) begin n_err++; $display("FAIL ckpt_pre_free got %0d want 22", free_count); end
    restore_valid = 1'b1; restore_id = 2'd2; alloc_cnt = 2'd2;
    rel_valid = 2'b01; rel_preg = {6'd0, 6'd33};
    step();
    idle_inputs();
    $display("restore slot2: free=%0d preg=(%0d,%0d)", free_count, alloc_preg[5:0], alloc_preg[11:6]);
    n_cmp++; if (free_count !== 6'd29) begin n_err++; $display("FAIL restore_free got %0d want 29", free_count); end
    n_cmp++; if (alloc_preg !== {6'd37, 6'd36}) begin n_err++;
      $display("FAIL restore_preg got (%0d,%0d) want (36,37)", alloc_preg[5:0], alloc_preg[11:6]); end
    // Save alongside an allocation must capture the post-allocation head.
    alloc_cnt = 2'd2; ckpt_save = 1'b1; ckpt_save_id = 2'd3;
    step();
    ckpt_save = 1'b0;
    step();
    restore_valid = 1'b1; restore_id = 2'd3;
    step();
    idle_inputs();
    $display("restore slot3: free=%0d preg=(%0d,%0d)", free_count, alloc_preg[5:0], alloc_preg[11:6]);
    n_cmp++; if (free_count !== 6'd27) begin n_err++; $display("FAIL restore3_free got %0d want 27", free_count); end
    n_cmp++; if (alloc_preg !== {6'd39, 6'd38}) begin n_err++;
      $display("FAIL restore3_preg got (%0d,%0d) want (38,39)", alloc_preg[5:0], alloc_preg[11:6]); end
  endtask

  task automatic test_steady_wrap();
    logic [5:0] e0, e1;
    do_reset();
    alloc_cnt = 2'd2;
    for (int k = 0; k < 11; k++) step();
    alloc_cnt = 2'd0;
    n_cmp++; if (free_count !== 6'd10) begin n_err++; $display("FAIL steady_start got %0d want 10", free_count); end
    for (int c = 0; c < 40; c++) begin
      e0 = 6'(54 + (2*c) % 10);
      e1 = e0 + 6'd1;
      alloc_cnt = 2'd2; rel_valid = 2'b11; rel_preg = {e1, e0};
      n_cmp++; if (alloc_preg !== {e1, e0}) begin n_err++;
        $display("FAIL steady_preg c=%0d got (%0d,%0d) want (%0d,%0d)", c,
                 alloc_preg[5:0], alloc_preg[11:6], e0, e1); end
      step();
      $display("steady %0d: alloc/release (%0d,%0d) free=%0d", c, e0, e1, free_count);
      n_cmp++; if (free_count !== 6'd10) begin n_err++;
        $display("FAIL steady_free c=%0d got %0d want 10", c, free_count); end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_inputs();
    $display("mid-run reset: free=%0d ready=%0d preg=(%0d,%0d)",
             free_count, alloc_ready, alloc_preg[5:0], alloc_preg[11:6]);
    n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL midrst_free got %0d want 32", free_count); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %0d want 1", alloc_ready); end
    test_alloc_drain();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alloc_drain();
    test_release_from_empty();
    test_release_r0();
    test_overflow();
    test_ckpt_restore();
    test_steady_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
